// File: rtl/psum_drain.sv
// Psum drain: reads a run of scratchpad words (with address wrap) and streams them out
// over valid/ready, buffering returned data so downstream stalls never drop a word.
module psum_drain #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_entries,
  output logic              spad_rd,
  output logic [ADDR_W-1:0] spad_addr,
  input  logic [DATA_W-1:0] spad_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW = ADDR_W + 1;
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int OW = $clog2(FIFO_D + 3);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     num_q;
  logic [CW-1:0]     issued;
  logic [CW-1:0]     push_idx;
  logic [ADDR_W-1:0] next_addr;
  logic              rd_d1;
  logic [DATA_W:0]   mem [FIFO_D];
  logic [PW-1:0]     wp, rp;
  logic [OW-1:0]     count;

  logic [CW-1:0]     num_clamped;
  logic              accept;
  logic              push, pop, push_last, last_hs, issue;
  logic [OW-1:0]     occ_after;
  logic [DATA_W:0]   head;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign num_clamped = (num_entries > CW'(DEPTH)) ? CW'(DEPTH) : num_entries;
  assign accept      = (state == IDLE) && start;

  assign head      = mem[rp];
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_last  = out_valid & head[DATA_W];

  assign push      = rd_d1;
  assign push_last = (push_idx == num_q - CW'(1));
  assign pop       = out_valid & out_ready;
  assign last_hs   = pop & out_last;

  // Occupancy the FIFO will have after this edge, counting the read still in its
  // return cycle; a new read may only issue if a slot remains for it.
  assign occ_after = count + OW'(push) + OW'(spad_rd) - OW'(pop);
  assign issue     = (state == RUN) && !last_hs && (issued < num_q) &&
                     (occ_after < OW'(FIFO_D));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (num_clamped == '0) ? FIN : RUN;
      RUN:  if (last_hs) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      FIN:     begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // ---------------- read issue ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spad_rd   <= 1'b0;
      spad_addr <= '0;
      next_addr <= '0;
      issued    <= '0;
      num_q     <= '0;
      rd_d1     <= 1'b0;
    end else begin
      rd_d1 <= spad_rd;
      if (accept) begin
        num_q     <= num_clamped;
        spad_addr <= base_addr;
        next_addr <= addr_inc(base_addr);
        spad_rd   <= (num_clamped != '0);
        issued    <= (num_clamped != '0) ? CW'(1) : '0;
      end else if (issue) begin
        spad_rd   <= 1'b1;
        spad_addr <= next_addr;
        next_addr <= addr_inc(next_addr);
        issued    <= issued + CW'(1);
      end else begin
        spad_rd   <= 1'b0;
      end
    end
  end

  // ---------------- return buffer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_D; i++) mem[i] <= '0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      push_idx <= '0;
    end else begin
      if (accept) push_idx <= '0;
      if (push) begin
        mem[wp]  <= {push_last, spad_data};
        wp       <= ptr_inc(wp);
        push_idx <= push_idx + CW'(1);
      end
      if (pop) rp <= ptr_inc(rp);
      unique case ({push, pop})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: a registered-read scratchpad model feeds the DUT, and every
// accepted drain is predicted as a queue of expected addresses and output words.
module tb_psum_drain;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] base_addr = '0;
  logic [6:0] num_entries = '0;
  logic       spad_rd;
  logic [5:0] spad_addr;
  logic [7:0] spad_data = '0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       done;

  psum_drain dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_entries(num_entries), .spad_rd(spad_rd), .spad_addr(spad_addr),
    .spad_data(spad_data), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [64];
  always @(posedge clk) if (spad_rd) spad_data <= mem[spad_addr];

  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] exp_q [$];
  logic [5:0] addr_q [$];
  int         rd_total = 0, pop_total = 0, done_cnt = 0, vld_cnt = 0;
  logic       hold_pend = 1'b0;
  logic [8:0] hold_w = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      rd_total  = 0;
      pop_total = 0;
      hold_pend = 1'b0;
    end else begin
      if (spad_rd) begin
        rd_total++;
        chk("rd_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) chk("rd_addr", spad_addr, addr_q.pop_front());
        chk("outstanding_le4", (rd_total - pop_total) <= 4, 1);
      end
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_word", {out_last, out_data}, hold_w);
      end
      hold_pend = out_valid && !out_ready;
      hold_w    = {out_last, out_data};
      if (out_valid) vld_cnt++;
      if (out_valid && out_ready) begin
        pop_total++;
        chk("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("out_word", {out_last, out_data}, exp_q.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  // Drive a start pulse; when model=1 the drain is expected to be accepted.
  task automatic do_start(input logic [5:0] b, input logic [6:0] n, input bit model);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_entries = n;
    if (model) begin
      int m;
      m = (n > 7'd64) ? 64 : int'(n);
      for (int i = 0; i < m; i++) begin
        addr_q.push_back(6'((int'(b) + i) % 64));
        exp_q.push_back({(i == m - 1), mem[(int'(b) + i) % 64]});
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("done_seen", seen, 1);
    out_ready = 1'b1;
    chk("drain_complete", exp_q.size(), 0);
    chk("addr_all_issued", addr_q.size(), 0);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_single_cycle", done, 0);
  endtask

  initial begin
    int d0, r0, p0, v0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 8'h10);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_spad_rd", spad_rd, 0);
    chk("rst_spad_addr", spad_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // basic latency: start in cycle 0
    d0 = done_cnt;
    do_start(6'd0, 7'd4, 1'b1);
    @(negedge clk);
    chk("basic_c1_rd", spad_rd, 1);
    chk("basic_c1_addr", spad_addr, 0);
    chk("basic_c1_busy", busy, 1);
    @(negedge clk);
    chk("basic_c2_valid", out_valid, 0);
    @(negedge clk);
    chk("basic_c3_valid", out_valid, 1);
    chk("basic_c3_data", out_data, 8'h10);
    chk("basic_c3_last", out_last, 0);
    repeat (3) @(negedge clk);
    chk("basic_c6_data", out_data, 8'h13);
    chk("basic_c6_last", out_last, 1);
    @(negedge clk);
    chk("basic_c7_done", done, 1);
    @(negedge clk);
    chk("basic_c8_busy", busy, 0);
    chk("basic_one_done", done_cnt - d0, 1);
    chk("basic_complete", exp_q.size(), 0);

    // address wrap
    d0 = done_cnt;
    do_start(6'd62, 7'd4, 1'b1);
    wait_done(30, 1'b0);
    chk("wrap_one_done", done_cnt - d0, 1);

    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);

    // backpressure: ready low for cycles 2..12
    d0 = done_cnt; r0 = rd_total; p0 = pop_total;
    do_start(6'($urandom), 7'd8, 1'b1);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_reads_capped", rd_total - r0, 4);
    chk("bp_no_pop", pop_total - p0, 0);
    chk("bp_valid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(40, 1'b0);
    chk("bp_all_words", pop_total - p0, 8);
    chk("bp_one_done", done_cnt - d0, 1);

    // zero length
    d0 = done_cnt; r0 = rd_total; v0 = vld_cnt;
    do_start(6'd5, 7'd0, 1'b1);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_no_rd", spad_rd, 0);
    @(negedge clk);
    chk("zero_idle", busy, 0);
    chk("zero_rd_count", rd_total - r0, 0);
    chk("zero_no_valid", vld_cnt - v0, 0);
    chk("zero_one_done", done_cnt - d0, 1);

    // clamp 70 -> 64
    d0 = done_cnt; p0 = pop_total;
    do_start(6'($urandom), 7'd70, 1'b1);
    wait_done(200, 1'b0);
    chk("clamp_words", pop_total - p0, 64);
    chk("clamp_one_done", done_cnt - d0, 1);

    // start while busy is ignored
    d0 = done_cnt; p0 = pop_total;
    do_start(6'd10, 7'd16, 1'b1);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; base_addr = 6'd40; num_entries = 7'd3;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100, 1'b0);
    chk("busy_start_words", pop_total - p0, 16);
    chk("busy_start_one_done", done_cnt - d0, 1);

    // async reset mid-drain
    d0 = done_cnt; p0 = pop_total;
    do_start(6'd20, 7'd8, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (pop_total - p0 >= 3) break;
    end
    chk("rst_mid_reached", pop_total - p0 >= 3, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_rd", spad_rd, 0);
    chk("rst_mid_busy", busy, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", busy, 0);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    do_start(6'($urandom), 7'd8, 1'b1);
    wait_done(60, 1'b0);
    chk("rst_restart_one_done", done_cnt - d0, 1);

    // randomized drains with random backpressure
    for (int t = 0; t < 6; t++) begin
      d0 = done_cnt;
      do_start(6'($urandom), 7'($urandom_range(1, 70)), 1'b1);
      wait_done(600, 1'b1);
      chk("rand_one_done", done_cnt - d0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
